instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle sequencer for the RISC datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Handles the instruction- and data-memory req/ready handshakes. Gates PC update, IR load and register writeback.
//  Sits beside the main opcode decoder: that decoder supplies per-opcode datapath controls; this block decides WHEN they take effect.
// PARAMETERS
//  OPC_W    6    opcode width
//  TIMEOUT  15   max cycles a req may wait for ready before ERR; 0 disables timeout
//  CNT_W    16   width of retired-instruction counter
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst          in   1      synchronous, active-high reset
//  start        in   1      leave IDLE and begin fetching
//  opcode       in   OPC_W  IR[31:26]; valid from DECODE onward
//  imem_ready   in   1      instruction memory data valid
//  dmem_ready   in   1      data memory access complete
//  imem_req     out  1      instruction fetch request
//  ir_load      out  1      load IR (imem_req & imem_ready in FETCH)
//  dmem_req     out  1      data memory request
//  dmem_we      out  1      data memory write (store only), valid with dmem_req
//  reg_wr_en    out  1      enable register-file write this cycle
//  pc_update    out  1      commit next PC (retire) this cycle
//  busy         out  1      state not IDLE/HALT/ERR
//  halted       out  1      in HALT
//  err          out  1      in ERR (illegal opcode or timeout)
//  state        out  3      current state code, debug
//  retired_cnt  out  CNT_W  count of pc_update pulses
// BEHAVIOUR
//  States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6 ERR=7. Outputs are decoded from the state register plus the latched op class.
//  Only ir_load also depends on imem_ready.
//  Reset (rst=1 at edge): state=IDLE, retired_cnt=0, wait_cnt=0, op_class=NONE. rst overrides every other event.
//  Cycle after reset, all outputs are 0 and state=0.
//  IDLE: start=1 -> FETCH. start is ignored in every other state.
//  FETCH: imem_req=1 each cycle. imem_ready=1 -> ir_load=1 that cycle, -> DECODE.
//    Otherwise wait_cnt++. wait_cnt==TIMEOUT-1 with ready low -> ERR (when TIMEOUT!=0).
//  DECODE (1 cycle): classify opcode, latch op_class.
//    ALU = 0,1,2,7,8; BR = 3,4; LD = 5; ST = 6; CALL = 9; HLT = 6'b111111; anything else -> ERR.
//  EXEC (1 cycle): BR -> pc_update=1, -> FETCH. LD/ST -> MEM. ALU/CALL -> WB. HLT -> HALT without retiring.
//  MEM: dmem_req=1, dmem_we=(op_class==ST); held stable until dmem_ready=1. Same timeout rule as FETCH.
//    On ready: LD -> WB; ST -> pc_update=1, -> FETCH.
//  WB (1 cycle): reg_wr_en=1, pc_update=1, -> FETCH.
//  wait_cnt clears on every entry to FETCH or MEM.
//  retired_cnt increments on each cycle with pc_update=1; wraps modulo 2^CNT_W.
//  HALT and ERR: sticky until rst; all req/enable outputs 0.
//  Latency: BR=3 cycles, ST=4, ALU/CALL=4, LD=5 (zero-wait memory, FETCH through retire inclusive).
//  Invariants: imem_req and dmem_req are never high together. reg_wr_en=1 implies pc_update=1.
//  ready seen outside its request state is ignored.
// STRUCTURE
//  Shared package seq_pkg: state localparams, op_class codes (NONE,ALU,BR,LD,ST,CALL,HLT), opcode constants, HALT_OPC.
//  Sub-module op_classifier: combinational opcode -> op_class + illegal flag; instantiated once, sampled in DECODE.
//  FSM, wait counter and retire counter stay in this module.
// TESTING
//  1. rst, start, opcode=0, zero-wait memory -> states 1,2,3,5,1; reg_wr_en and pc_update high in WB; retired_cnt=1.
//  2. opcode=5 (load), dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, then WB with reg_wr_en=1.
//  3. opcode=6 (store) -> dmem_we=1 with dmem_req; no reg_wr_en; pc_update on the ready cycle.
//  4. opcode=3 (branch) -> pc_update in EXEC, back to FETCH after 3 cycles, no reg_wr_en.
//  5. opcode=6'b101010 -> ERR, err=1 sticky. imem_ready held 0 for 15 cycles -> ERR. rst -> IDLE, retired_cnt=0.
//  6. rst asserted mid-MEM -> next cycle state=0, dmem_req=0. Opcode 6'b111111 -> halted=1, retired_cnt unchanged.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer:
// FSM state codes, latched operation classes and the opcode map.
package seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERR    = 3'd7
   } seq_state_e;

   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_ALU  = 3'd1,
      CLS_BR   = 3'd2,
      CLS_LD   = 3'd3,
      CLS_ST   = 3'd4,
      CLS_CALL = 3'd5,
      CLS_HLT  = 3'd6
   } op_class_e;

   localparam logic [5:0] OP_ADD   = 6'd0;
   localparam logic [5:0] OP_SUB   = 6'd1;
   localparam logic [5:0] OP_AND   = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd3;
   localparam logic [5:0] OP_BNE   = 6'd4;
   localparam logic [5:0] OP_LW    = 6'd5;
   localparam logic [5:0] OP_SW    = 6'd6;
   localparam logic [5:0] OP_OR    = 6'd7;
   localparam logic [5:0] OP_XOR   = 6'd8;
   localparam logic [5:0] OP_CALL  = 6'd9;
   localparam logic [5:0] HALT_OPC = 6'b111111;

endpackage

// File: rtl/op_classifier.sv
// Combinational opcode classifier: maps the IR opcode field onto an
// operation class and flags opcodes that have no defined class.
module op_classifier
   import seq_pkg::*;
#(
   parameter int unsigned OPC_W = 6
) (
   input  logic [OPC_W-1:0] i_opcode,
   output logic [2:0]       o_class,
   output logic             o_illegal
);

   always_comb begin
      o_class   = CLS_NONE;
      o_illegal = 1'b0;
      if (i_opcode == '1) begin
         o_class = CLS_HLT;
      end else begin
         case (i_opcode)
            OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_AND),
            OPC_W'(OP_OR),  OPC_W'(OP_XOR):  o_class = CLS_ALU;
            OPC_W'(OP_BEQ), OPC_W'(OP_BNE):  o_class = CLS_BR;
            OPC_W'(OP_LW):                   o_class = CLS_LD;
            OPC_W'(OP_SW):                   o_class = CLS_ST;
            OPC_W'(OP_CALL):                 o_class = CLS_CALL;
            default:                         o_illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer. Owns the memory handshakes,
// request timeouts and the retired-instruction counter; gates IR/PC/RF updates.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned OPC_W   = 6,
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [OPC_W-1:0] opcode,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_load,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             reg_wr_en,
   output logic             pc_update,
   output logic             busy,
   output logic             halted,
   output logic             err,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired_cnt
);

   localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);

   seq_state_e        r_state;
   seq_state_e        w_next_state;
   op_class_e         r_op_class;
   op_class_e         w_next_class;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0]  r_retired_cnt;

   logic [2:0]        w_class_raw;
   op_class_e         w_class;
   logic              w_illegal;
   logic              w_timeout;
   logic              w_wait_clr;
   logic              w_wait_inc;

   op_classifier #(
      .OPC_W (OPC_W)
   ) u_classifier (
      .i_opcode  (opcode),
      .o_class   (w_class_raw),
      .o_illegal (w_illegal)
   );

   assign w_class   = op_class_e'(w_class_raw);
   assign w_timeout = (TIMEOUT != 0) && (r_wait_cnt == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_op_class    <= CLS_NONE;
         r_wait_cnt    <= '0;
         r_retired_cnt <= '0;
      end else begin
         r_state    <= w_next_state;
         r_op_class <= w_next_class;
         if (w_wait_clr) begin
            r_wait_cnt <= '0;
         end else if (w_wait_inc) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         if (pc_update) begin
            r_retired_cnt <= r_retired_cnt + 1'b1;
         end
      end
   end

   // Every transition into FETCH or MEM raises w_wait_clr so each request starts a fresh timeout window.
   always_comb begin
      w_next_state = r_state;
      w_next_class = r_op_class;
      w_wait_clr   = 1'b0;
      w_wait_inc   = 1'b0;
      imem_req     = 1'b0;
      ir_load      = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      reg_wr_en    = 1'b0;
      pc_update    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next_state = S_FETCH;
               w_wait_clr   = 1'b1;
            end
         end

         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_load      = 1'b1;
               w_next_state = S_DECODE;
            end else if (w_timeout) begin
               w_next_state = S_ERR;
            end else begin
               w_wait_inc = 1'b1;
            end
         end

         S_DECODE: begin
            if (w_illegal) begin
               w_next_class = CLS_NONE;
               w_next_state = S_ERR;
            end else begin
               w_next_class = w_class;
               w_next_state = S_EXEC;
            end
         end

         S_EXEC: begin
            case (r_op_class)
               CLS_BR: begin
                  pc_update    = 1'b1;
                  w_next_state = S_FETCH;
                  w_wait_clr   = 1'b1;
               end
               CLS_LD, CLS_ST: begin
                  w_next_state = S_MEM;
                  w_wait_clr   = 1'b1;
               end
               CLS_ALU, CLS_CALL: w_next_state = S_WB;
               CLS_HLT:           w_next_state = S_HALT;
               default:           w_next_state = S_ERR;
            endcase
         end

         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (r_op_class == CLS_ST);
            if (dmem_ready) begin
               if (r_op_class == CLS_ST) begin
                  pc_update    = 1'b1;
                  w_next_state = S_FETCH;
                  w_wait_clr   = 1'b1;
               end else begin
                  w_next_state = S_WB;
               end
            end else if (w_timeout) begin
               w_next_state = S_ERR;
            end else begin
               w_wait_inc = 1'b1;
            end
         end

         S_WB: begin
            reg_wr_en    = 1'b1;
            pc_update    = 1'b1;
            w_next_state = S_FETCH;
            w_wait_clr   = 1'b1;
         end

         default: begin
            w_next_state = r_state;
         end
      endcase
   end

   assign busy        = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_ERR);
   assign halted      = (r_state == S_HALT);
   assign err         = (r_state == S_ERR);
   assign state       = r_state;
   assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized scoreboard bench for instr_sequencer: a per-instruction latency
// model feeds a queue that a negedge monitor drains on retire/halt/error events.
module tb_instr_sequencer;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [5:0]    opcode;
   logic          imem_ready, dmem_ready;
   logic          imem_req, ir_load, dmem_req, dmem_we, reg_wr_en, pc_update;
   logic          busy, halted, err;
   logic [2:0]    state;
   logic [CW-1:0] retired_cnt;

   instr_sequencer #(
      .OPC_W   (6),
      .TIMEOUT (15),
      .CNT_W   (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .opcode      (opcode),
      .imem_ready  (imem_ready),
      .dmem_ready  (dmem_ready),
      .imem_req    (imem_req),
      .ir_load     (ir_load),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .reg_wr_en   (reg_wr_en),
      .pc_update   (pc_update),
      .busy        (busy),
      .halted      (halted),
      .err         (err),
      .state       (state),
      .retired_cnt (retired_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // kind: 0 retire, 1 halt, 2 error. off: cycles from first FETCH cycle to event cycle.
   typedef struct {
      int kind;
      int off;
      bit wr;
      bit we;
      int cnt;
   } exp_t;

   exp_t sb[$];
   int   model_cnt;

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   // 0 ALU, 1 BR, 2 LD, 3 ST, 4 CALL, 5 HLT, 6 illegal
   function automatic int ref_class(input logic [5:0] o);
      if (o inside {6'd0, 6'd1, 6'd2, 6'd7, 6'd8}) return 0;
      if (o inside {6'd3, 6'd4}) return 1;
      if (o == 6'd5) return 2;
      if (o == 6'd6) return 3;
      if (o == 6'd9) return 4;
      if (o == 6'h3F) return 5;
      return 6;
   endfunction

   // ---------------- monitor ----------------
   int cyc = 0;
   int t0 = 0;
   bit saw_we, p_req, p_halt, p_err;

   always @(negedge clk) begin
      exp_t e;
      int   kind;
      cyc++;
      if (!rst) begin
         chk("req_exclusive", int'(imem_req & dmem_req), 0);
         chk("ir_load_gate", int'(ir_load), int'(imem_req & imem_ready));
         if (reg_wr_en) chk("wr_implies_pc", int'(pc_update), 1);
         if (imem_req && !p_req) begin
            t0     = cyc;
            saw_we = 1'b0;
         end
         if (dmem_req && dmem_we) saw_we = 1'b1;
         if (pc_update || (halted && !p_halt) || (err && !p_err)) begin
            kind = pc_update ? 0 : (halted ? 1 : 2);
            if (sb.size() == 0) begin
               chk("unexpected_event", kind, -1);
            end else begin
               e = sb.pop_front();
               chk("event_kind", kind, e.kind);
               chk("event_latency", cyc - t0, e.off);
               if (kind == 0) begin
                  chk("retire_reg_wr_en", int'(reg_wr_en), int'(e.wr));
                  chk("retire_dmem_we_seen", int'(saw_we), int'(e.we));
                  chk("retire_count", int'(retired_cnt), e.cnt);
                  chk("retire_busy", int'(busy), 1);
               end
            end
         end
      end
      p_req  = imem_req;
      p_halt = halted;
      p_err  = err;
   end

   // ---------------- driver helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit sig(input int sel);
      case (sel)
         0:       return imem_req;
         1:       return dmem_req;
         2:       return halted;
         default: return err;
      endcase
   endfunction

   task automatic wait_sig(input int sel, input string name);
      int n = 0;
      while (!sig(sel) && n < 40) begin
         step();
         n++;
      end
      chk(name, int'(sig(sel)), 1);
   endtask

   task automatic issue(input logic [5:0] opc, input int f, input int d);
      int   cls;
      exp_t e;
      cls   = ref_class(opc);
      e.wr  = 1'b0;
      e.we  = 1'b0;
      e.cnt = model_cnt;
      e.kind = 0;
      case (cls)
         0, 4: begin e.off = f + 3; e.wr = 1'b1; end
         1:    e.off = f + 2;
         2:    begin e.off = f + 4 + d; e.wr = 1'b1; end
         3:    begin e.off = f + 3 + d; e.we = 1'b1; end
         5:    begin e.kind = 1; e.off = f + 3; end
         default: begin e.kind = 2; e.off = f + 2; end
      endcase
      if (e.kind == 0) model_cnt = (model_cnt + 1) % (1 << CW);
      sb.push_back(e);

      wait_sig(0, "wait_imem_req");
      repeat (f) begin
         imem_ready = 1'b0;
         dmem_ready = 1'($urandom);
         opcode     = 6'($urandom);
         step();
      end
      imem_ready = 1'b1;
      opcode     = opc;
      dmem_ready = 1'($urandom);
      step();
      imem_ready = 1'b0;
      dmem_ready = 1'b0;

      if (cls == 2 || cls == 3) begin
         wait_sig(1, "wait_dmem_req");
         repeat (d) begin
            dmem_ready = 1'b0;
            imem_ready = 1'($urandom);
            step();
         end
         dmem_ready = 1'b1;
         imem_ready = 1'($urandom);
         step();
         dmem_ready = 1'b0;
         imem_ready = 1'b0;
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      model_cnt = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int f, d;
      rst = 1'b1; start = 1'b0; opcode = '0;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      model_cnt = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_state", int'(state), 0);
      chk("rst_imem_req", int'(imem_req), 0);
      chk("rst_ir_load", int'(ir_load), 0);
      chk("rst_dmem_req", int'(dmem_req), 0);
      chk("rst_dmem_we", int'(dmem_we), 0);
      chk("rst_reg_wr_en", int'(reg_wr_en), 0);
      chk("rst_pc_update", int'(pc_update), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_halted", int'(halted), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_retired_cnt", int'(retired_cnt), 0);

      step();
      pulse_start();
      issue(6'd0, 0, 0);
      issue(6'd5, 0, 3);
      issue(6'd6, 0, 0);
      issue(6'd3, 0, 0);
      issue(6'd9, 1, 0);
      issue(6'd6, 2, 14);
      issue(6'd5, 14, 0);

      for (int i = 0; i < 150; i++) begin
         f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : 0;
         d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : 0;
         issue(6'($urandom_range(0, 9)), f, d);
      end

      // illegal opcode: sticky ERR, start and readies ignored
      issue(6'b101010, 2, 0);
      wait_sig(3, "wait_err_illegal");
      repeat (4) begin
         start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
         @(negedge clk);
         chk("err_sticky", int'(err), 1);
         chk("err_state", int'(state), 7);
         chk("err_busy", int'(busy), 0);
         chk("err_no_req", int'(imem_req | dmem_req | pc_update | reg_wr_en), 0);
         step();
      end
      start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      pulse_reset();
      @(negedge clk);
      chk("rst_after_err_state", int'(state), 0);
      chk("rst_after_err_cnt", int'(retired_cnt), 0);
      chk("rst_after_err_err", int'(err), 0);
      step();

      // fetch timeout: 15 FETCH cycles without ready, then ERR
      pulse_start();
      sb.push_back('{kind: 2, off: 15, wr: 1'b0, we: 1'b0, cnt: 0});
      wait_sig(3, "wait_err_timeout");
      step();
      pulse_reset();

      // reset in the middle of a load's MEM phase
      step();
      pulse_start();
      issue(6'd0, 0, 0);
      wait_sig(0, "wait_imem_req_ld");
      imem_ready = 1'b1; opcode = 6'd5;
      step();
      imem_ready = 1'b0;
      wait_sig(1, "wait_dmem_req_ld");
      step();
      step();
      pulse_reset();
      @(negedge clk);
      chk("midmem_rst_state", int'(state), 0);
      chk("midmem_rst_dmem_req", int'(dmem_req), 0);
      chk("midmem_rst_cnt", int'(retired_cnt), 0);
      step();

      // halt: sticky, does not retire
      pulse_start();
      issue(6'd0, 0, 0);
      issue(6'h3F, 1, 0);
      wait_sig(2, "wait_halted");
      repeat (3) begin
         start = 1'b1; imem_ready = 1'b1;
         @(negedge clk);
         chk("halt_sticky", int'(halted), 1);
         chk("halt_state", int'(state), 6);
         chk("halt_cnt", int'(retired_cnt), 1);
         chk("halt_no_pc", int'(pc_update), 0);
         chk("halt_busy", int'(busy), 0);
         step();
      end
      start = 1'b0; imem_ready = 1'b0;
      @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      repeat (60000) @(posedge clk);
      errors++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
